// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch and data-memory accesses onto one fixed-latency memory port.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [DATA_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              if_busy,
  output logic              dm_busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  if (MEM_LAT < 1 || STARVE_MAX < 1) $error("mem_arbiter: MEM_LAT and STARVE_MAX must be >= 1");
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic gnt_dm, we_q, grant, pick_dm, force_if, issue, wr;
  logic en_d, we_d, if_ack_d, dm_ack_d;
  logic [DATA_W-1:0] addr_d, wdata_d;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] dm_streak;
  assign force_if = if_req && dm_streak == SW'(STARVE_MAX);
  always_ff @(posedge clk or posedge reset)
    if (reset) dm_streak <= '0;
    else if (issue) dm_streak <= pick_dm && if_req ? (force_if ? dm_streak : dm_streak + 1'b1) : '0;
`else
  assign force_if = 1'b0;
`endif
  assign grant   = if_req || dm_req;
  assign pick_dm = dm_req && !force_if;
  assign if_busy = if_req && !if_ack;
  assign dm_busy = dm_req && !dm_ack;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = grant ? ISSUE : IDLE;
      ISSUE:   state_n = we_q ? DONE : WAIT;
      WAIT:    state_n = cnt == '0 ? DONE : WAIT;
      default: state_n = IDLE;
    endcase
  end
  // Registered outputs are computed one cycle early from the grant decision and next state.
  always_comb begin
    issue    = state == IDLE && grant;
    wr       = issue && pick_dm && dm_we;
    en_d     = issue;
    we_d     = wr;
    addr_d   = issue ? (pick_dm ? dm_addr : if_addr) : '0;
    wdata_d  = wr ? dm_wdata : '0;
    if_ack_d = state_n == DONE && !gnt_dm;
    dm_ack_d = state_n == DONE && gnt_dm;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
    end else begin
      mem_en    <= en_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      if_ack    <= if_ack_d;
      dm_ack    <= dm_ack_d;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      gnt_dm   <= 1'b0;
      we_q     <= 1'b0;
      cnt      <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      gnt_dm   <= issue ? pick_dm : gnt_dm;
      we_q     <= issue ? wr : we_q;
      cnt      <= state == ISSUE ? CW'(MEM_LAT - 1) : state == WAIT ? cnt - 1'b1 : cnt;
      if_rdata <= state == WAIT && cnt == '0 && !gnt_dm ? mem_rdata : if_rdata;
      dm_rdata <= state == WAIT && cnt == '0 && gnt_dm ? mem_rdata : dm_rdata;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter with a 2-cycle pipelined memory model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int W = 32, LAT = 2, SMAX = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int STARVE_EXP = 4;
`else
  localparam int STARVE_EXP = 20;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [W-1:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic if_ack, dm_ack, mem_en, mem_we, if_busy, dm_busy;
  logic [W-1:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  mem_arbiter #(.DATA_W(W), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .if_busy(if_busy), .dm_busy(dm_busy)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // Memory: preset words overlaid by writes; read data valid for exactly one cycle, LAT edges after sampling.
  logic [W-1:0] wmem [0:63];
  logic [63:0] wvalid = '0;
  logic [W-1:0] p0 = '0, p1 = '0;
  assign mem_rdata = p1;
  function automatic logic [W-1:0] init_val(input logic [5:0] i);
    case (i)
      6'd1:    return 32'h8C130004;
      6'd4:    return 32'hAC140008;
      6'd8:    return 32'h12345678;
      default: return 32'hA5A50000 | 32'(i);
    endcase
  endfunction
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      wmem[mem_addr[7:2]] <= mem_wdata;
      wvalid[mem_addr[7:2]] <= 1'b1;
    end
    p0 <= mem_en && !mem_we ? (wvalid[mem_addr[7:2]] ? wmem[mem_addr[7:2]] : init_val(mem_addr[7:2])) : 32'hDEADBEEF;
    p1 <= p0;
  end
  typedef struct {logic [W-1:0] d; int c;} exp_t;
  exp_t iq[$], dq[$];
  exp_t e;
  int checks = 0, errors = 0;
  int dm_cnt = 0, snap = 0, en_cnt = 0, wr_cnt = 0;
  logic [W-1:0] en_addr = '0, wr_data = '0, last_dm = '0;
  task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endtask
  task automatic fail(input string n, input string why);
    checks++;
    errors++;
    $display("FAIL %s: %s", n, why);
  endtask
  // Monitor: pops expectations on each ack and checks per-cycle invariants.
  always @(negedge clk) if (!reset) begin
    chk("if_busy", 32'(if_busy), 32'(if_req && !if_ack));
    chk("dm_busy", 32'(dm_busy), 32'(dm_req && !dm_ack));
    if (!mem_en) chk("mem_idle_zero", 32'(mem_we) | mem_addr | mem_wdata, '0);
    if (mem_en) begin
      en_cnt++;
      en_addr = mem_addr;
      if (mem_we) begin
        wr_cnt++;
        wr_data = mem_wdata;
      end
    end
    if (if_ack) begin
      snap = dm_cnt;
      if (iq.size() == 0) fail("if_ack_spurious", "ack with no pending fetch");
      else begin
        e = iq.pop_front();
        chk("if_rdata", if_rdata, e.d);
        if (e.c != 0) chk("if_ack_cycle", cyc, e.c);
      end
    end
    if (dm_ack) begin
      dm_cnt++;
      if (dq.size() == 0) fail("dm_ack_spurious", "ack with no pending data access");
      else begin
        e = dq.pop_front();
        chk("dm_rdata", dm_rdata, e.d);
        if (e.c != 0) chk("dm_ack_cycle", cyc, e.c);
      end
    end
  end
  task automatic wait_ack(input bit dm, input int budget, input string n);
    int k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!(dm ? dm_ack : if_ack) && k < budget);
    if (!(dm ? dm_ack : if_ack)) fail(n, "timed out waiting for ack");
  endtask
  task automatic if_access(input logic [W-1:0] a, input logic [W-1:0] exp, input int off, input int budget);
    exp_t t;
    t.d = exp;
    t.c = off != 0 ? cyc + off : 0;
    iq.push_back(t);
    if_addr = a;
    if_req = 1'b1;
    wait_ack(1'b0, budget, "if_timeout");
    @(posedge clk);
    #1;
    if_req = 1'b0;
  endtask
  task automatic dm_access(input logic we, input logic [W-1:0] a, input logic [W-1:0] d, input logic [W-1:0] exp, input int off);
    exp_t t;
    t.d = we ? last_dm : exp;
    t.c = off != 0 ? cyc + off : 0;
    dq.push_back(t);
    if (!we) last_dm = exp;
    dm_we = we;
    dm_addr = a;
    dm_wdata = d;
    dm_req = 1'b1;
    wait_ack(1'b1, 50, "dm_timeout");
    @(posedge clk);
    #1;
    dm_req = 1'b0;
    dm_we = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int b0, b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", 32'({mem_en, mem_we, if_ack, dm_ack}), '0);
    chk("reset_data", mem_addr | mem_wdata | if_rdata | dm_rdata, '0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    b0 = en_cnt;
    if_access(32'h4, 32'h8C130004, 4, 20);
    chk("fetch_en_count", 32'(en_cnt - b0), 1);
    chk("fetch_mem_addr", en_addr, 32'h4);
    b0 = en_cnt;
    b1 = wr_cnt;
    dm_access(1'b1, 32'h8, 32'h14, '0, 2);
    chk("write_en_count", 32'(en_cnt - b0), 1);
    chk("write_we_count", 32'(wr_cnt - b1), 1);
    chk("write_mem_addr", en_addr, 32'h8);
    chk("write_mem_wdata", wr_data, 32'h14);
    dm_access(1'b0, 32'h8, '0, 32'h14, 4);
    fork
      dm_access(1'b0, 32'h10, '0, 32'hAC140008, 4);
      if_access(32'h4, 32'h8C130004, 9, 20);
    join
    b0 = dm_cnt;
    fork
      if_access(32'h4, 32'h8C130004, 0, 400);
      begin
        exp_t t;
        dm_we = 1'b1;
        dm_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
          dm_addr = 32'h40 + 32'(i * 4);
          dm_wdata = 32'(i);
          t.d = last_dm;
          t.c = 0;
          dq.push_back(t);
          wait_ack(1'b1, 50, "starve_dm_timeout");
          @(posedge clk);
          #1;
        end
        dm_req = 1'b0;
        dm_we = 1'b0;
      end
    join
    chk("starve_dm_before_fetch", 32'(snap - b0), 32'(STARVE_EXP));
    dm_access(1'b0, 32'h4C, '0, 32'h3, 4);
    dm_we = 1'b1;
    dm_addr = 32'h8;
    dm_wdata = 32'h99;
    dm_req = 1'b1;
    @(posedge clk);
    #1;
    chk("issue_mem_en", 32'(mem_en), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_ctrl", 32'({mem_en, mem_we, if_ack, dm_ack}), '0);
    chk("async_reset_data", mem_addr | mem_wdata | if_rdata | dm_rdata, '0);
    dm_req = 1'b0;
    dm_we = 1'b0;
    last_dm = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    dm_access(1'b0, 32'h8, '0, 32'h14, 4);
    dm_addr = 32'h10;
    dm_req = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    dm_req = 1'b0;
    #1;
    chk("wait_reset_rdata", dm_rdata, '0);
    last_dm = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    dm_access(1'b0, 32'h20, '0, 32'h12345678, 4);
    repeat (3) @(posedge clk);
    #1;
    chk("if_queue_drained", 32'(iq.size()), 0);
    chk("dm_queue_drained", 32'(dq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
